muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start_valid  input  1  an operation is offered this cycle.
REQ-005 SHALL have port start_ready  output  1  unit can accept an operation (IDLE only).
REQ-006 SHALL have port op  input  3  muldiv_op_type: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 SHALL have port operand_a  input  XLEN  rs1 value (multiplicand or dividend).
REQ-008 SHALL have port operand_b  input  XLEN  rs2 value (multiplier or divisor).
REQ-009 SHALL have port flush  input  1  abort the in-flight operation (branch or exception).
REQ-010 SHALL have port result_valid  output  1  result is available.
REQ-011 SHALL have port result_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  XLEN  RV32M-semantic result.
REQ-013 SHALL have port busy  output  1  high in BUSY or DONE; used by the hazard unit to stall ID/EX.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL accept an operation when start_valid and start_ready are both high, latching op, the operand magnitudes and the result sign in that cycle.
REQ-016 SHALL go IDLE -> BUSY on accept and run XLEN iterations: shift-add for multiply, restoring shift-subtract for divide, one bit per cycle.
REQ-017 SHALL go BUSY -> DONE after the XLEN-th iteration; result_valid rises XLEN+1 cycles after the accept edge.
REQ-018 SHALL hold result_valid and result stable in DONE until result_ready is high, then return to IDLE.
REQ-019 SHALL NOT let result_valid depend combinationally on result_ready.
REQ-020 SHALL apply sign correction (two's-complement negate) in the DONE transition, not on the output path.
REQ-021 SHALL use a 2*XLEN product: MUL returns the low half; MULH, MULHSU and MULHU return the high half with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-022 SHALL handle divide by zero as a fast path to DONE on the next cycle: DIV and DIVU give all-ones; REM and REMU give operand_a.
REQ-023 SHALL handle signed overflow (DIV or REM with operand_a = most-negative and operand_b = -1) as a fast path to DONE on the next cycle: DIV gives operand_a; REM gives 0.
REQ-024 SHALL give the remainder the sign of the dividend and truncate the quotient toward zero.
REQ-025 SHALL return to IDLE on the next edge from BUSY or DONE when flush is high, with no result_valid; flush takes priority over result_ready and over iteration completion.
REQ-026 SHALL ignore flush in IDLE, and SHALL NOT accept start_valid in the same cycle as flush.

Reset
REQ-027 SHALL, while reset_n is low, force state IDLE, the iteration counter to 0, and result, result_valid and busy to 0.
REQ-028 SHALL drive start_ready high as soon as reset is asserted; reset mid-operation discards the operation with no result.

Configuration
REQ-029 SHALL include the multiply datapath and the MUL* ops when the macro MULDIV_MUL_EN is defined.
REQ-030 SHALL, when MULDIV_MUL_EN is undefined, exclude the multiply datapath and treat MUL* ops as a fast path to DONE on the next cycle with result 0; divide behaviour is unchanged.

Structure
REQ-031 SHALL have muldiv_op_type (3-bit enum) and a MULDIV_FUNCT7 = 7'b0000001 constant added to package common.
REQ-032 SHALL extend control_type in package common with an is_muldiv bit.
REQ-033 SHALL have the iteration datapath (accumulator, shift, add/subtract step) as one sub-module, muldiv_datapath; the FSM, sign handling and fast paths stay in muldiv_unit.

Verification
REQ-034 SHALL check: DIV 20 / -3 -> result 0xFFFFFFFA; REM 20 / -3 -> 2; result_valid exactly 33 cycles after accept (XLEN=32).
REQ-035 SHALL check: DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; result_valid 1 cycle after accept.
REQ-036 SHALL check: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; each takes 1 cycle.
REQ-037 SHALL check: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; MUL -> 1.
REQ-038 SHALL check: flush 10 cycles into a DIV -> no result_valid, start_ready high the next cycle, and a following DIVU 7 / 2 returns 3.
REQ-039 SHALL check: result_ready held low 5 cycles in DONE -> result stable; reset_n pulsed low mid-BUSY -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/common_pkg.sv
// Core-wide shared types: RV32M op encoding, its funct7 and the decoded control bundle.
package common;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  // Encoding matches the RV32M funct3 field.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_type;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic is_muldiv;
  } control_type;

  function automatic logic op_a_signed(input muldiv_op_type o);
    return o inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op_b_signed(input muldiv_op_type o);
    return o inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// One-bit-per-cycle iteration datapath: shift-add multiply and restoring divide on magnitudes.
// The multiply step exists only when MULDIV_MUL_EN is defined.
module muldiv_datapath #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  // hi/lo hold product high/low for multiply, remainder/quotient for divide.
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN:0]   shifted, diff;
`ifdef MULDIV_MUL_EN
  logic [XLEN:0]   sum;
`endif

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
`ifdef MULDIV_MUL_EN
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
`endif
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
      b_d  = b_i;
    end else if (step_i && div_i) begin
      // Borrow out of the trial subtraction means restore.
      if (!diff[XLEN]) begin
        hi_d = diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = shifted[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end
`ifdef MULDIV_MUL_EN
    else if (step_i) begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling and fast paths around muldiv_datapath.
// Multiply support is compiled in only when MULDIV_MUL_EN is defined.
module muldiv_unit
  import common::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  muldiv_op_type   op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  muldiv_op_type   op_q;
  logic            neg_q, fast_q, result_valid_q, busy_q;
  logic [XLEN-1:0] fast_res_q, result_q;

  logic            accept, a_neg, b_neg, neg, div_zero, div_ovf, fast_hit, step;
  logic [XLEN-1:0] a_mag, b_mag, fast_res, dp_hi, dp_lo, iter_res;

  assign start_ready = (state_q == StIdle) && !flush;
  assign accept      = start_valid && start_ready;

  assign a_neg    = op_a_signed(op) && operand_a[XLEN-1];
  assign b_neg    = op_b_signed(op) && operand_b[XLEN-1];
  assign a_mag    = a_neg ? -operand_a : operand_a;
  assign b_mag    = b_neg ? -operand_b : operand_b;
  // Remainder follows the dividend; everything else follows the operand sign product.
  assign neg      = (op inside {REM, REMU}) ? a_neg : (a_neg ^ b_neg);
  assign div_zero = op[2] && (operand_b == '0);
  assign div_ovf  = (op inside {DIV, REM}) && (operand_a == MinNeg) && (operand_b == '1);

  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (div_zero) begin
      fast_hit = 1'b1;
      fast_res = op[1] ? operand_a : '1;
    end else if (div_ovf) begin
      fast_hit = 1'b1;
      fast_res = op[1] ? '0 : operand_a;
    end
`ifndef MULDIV_MUL_EN
    else if (!op[2]) begin
      fast_hit = 1'b1;
      fast_res = '0;
    end
`endif
  end

  assign step = (state_q == StBusy) && !fast_q && (cnt_q != CntW'(XLEN));

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .load_i (accept),
    .step_i (step),
    .div_i  (op_q[2]),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (dp_hi),
    .lo_o   (dp_lo)
  );

`ifdef MULDIV_MUL_EN
  logic [2*XLEN-1:0] prod_fix;
  assign prod_fix = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
`endif

  always_comb begin
    iter_res = '0;
    unique case (op_q)
      DIV, DIVU: iter_res = neg_q ? -dp_lo : dp_lo;
      REM, REMU: iter_res = neg_q ? -dp_hi : dp_hi;
`ifdef MULDIV_MUL_EN
      MUL:                 iter_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: iter_res = prod_fix[2*XLEN-1:XLEN];
`endif
      default: iter_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      op_q           <= MUL;
      neg_q          <= 1'b0;
      fast_q         <= 1'b0;
      fast_res_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StBusy;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            op_q       <= op;
            neg_q      <= neg;
            fast_q     <= fast_hit;
            fast_res_q <= fast_res;
          end
        end
        StBusy: begin
          if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (fast_q || (cnt_q == CntW'(XLEN))) begin
            state_q        <= StDone;
            result_valid_q <= 1'b1;
            result_q       <= fast_q ? fast_res_q : iter_res;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (flush || result_ready) begin
            state_q        <= StIdle;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule
